// File: rtl/config_loader_pkg.sv
// Shared definitions for the fabric configuration bus (loader and tile decode).
// Latency: n/a (constants, types and pure functions only).
// Backpressure: n/a.
//
// Contents: select-field codes for tile sub-blocks, address field positions,
// loader state encoding, and field-extraction helpers.
package config_loader_pkg;

  // Select codes carried in config_addr[31:16]; 0 never matches a sub-block.
  localparam logic [15:0] CONFIG_SB  = 16'd7;
  localparam logic [15:0] CONFIG_CB0 = 16'd6;
  localparam logic [15:0] CONFIG_CB1 = 16'd5;
  localparam logic [15:0] CONFIG_CLB = 16'd4;

  // Address field layout: tile_id in the low half, select in the high half.
  localparam int TILE_ID_LSB = 0;
  localparam int TILE_ID_W   = 16;
  localparam int SEL_LSB     = 16;
  localparam int SEL_W       = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GET_ADDR = 3'd1,
    ST_GET_DATA = 3'd2,
    ST_WRITE    = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  function automatic logic [SEL_W-1:0] sel_of(input logic [31:0] addr);
    return addr[SEL_LSB +: SEL_W];
  endfunction

  function automatic logic [TILE_ID_W-1:0] tile_of(input logic [31:0] addr);
    return addr[TILE_ID_LSB +: TILE_ID_W];
  endfunction

endpackage

// File: rtl/config_loader.sv
// Pairs a 32-bit word stream into (address, data) records and drives each legal record on the config bus.
// Latency: bus write starts 1 cycle after the data-word handshake; WRITE_CYCLES+2 cycles per record back-to-back.
// Backpressure: in_ready is low in IDLE/DONE and for the whole bus write; source may stall in_valid indefinitely.
//
// Ports:
//   clk, reset (async, active-low)      - clock and reset
//   start, num_records                  - begin a load of num_records records (ignored while busy)
//   in_valid, in_data, in_ready         - word stream, address word then data word per record
//   config_addr, config_data            - registered configuration bus to the tile array
//   busy, done, err_count               - load status; err_count counts skipped records, saturating
module config_loader
  import config_loader_pkg::*;
#(
  parameter logic [31:0] IDLE_ADDR    = 32'h0000_0000,
  parameter int unsigned WRITE_CYCLES = 1,
  parameter logic [15:0] SEL_MIN      = CONFIG_CLB,
  parameter logic [15:0] SEL_MAX      = CONFIG_SB
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] num_records,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic [31:0] config_addr,
  output logic [31:0] config_data,
  output logic        busy,
  output logic        done,
  output logic [7:0]  err_count
);

  // Hold counter is loaded with the index of the last write cycle and counts down to 0.
  localparam logic [3:0] HOLD_LAST = 4'(WRITE_CYCLES - 1);

  state_t      state;
  logic [31:0] addr_reg;
  logic [15:0] remaining;
  logic [3:0]  hold_cnt;

  logic hs;
  logic sel_ok;
  logic last_rec;

  assign hs       = in_valid && in_ready;
  assign sel_ok   = (sel_of(addr_reg) >= SEL_MIN) && (sel_of(addr_reg) <= SEL_MAX);
  assign last_rec = (remaining == 16'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      addr_reg    <= '0;
      remaining   <= '0;
      hold_cnt    <= '0;
      in_ready    <= 1'b0;
      config_addr <= IDLE_ADDR;
      config_data <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_count   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            err_count <= '0;
            if (num_records == 16'd0) begin
              state    <= ST_DONE;
              done     <= 1'b1;
              busy     <= 1'b0;
              in_ready <= 1'b0;
            end else begin
              remaining <= num_records;
              done      <= 1'b0;
              busy      <= 1'b1;
              in_ready  <= 1'b1;
              state     <= ST_GET_ADDR;
            end
          end
        end

        ST_GET_ADDR: begin
          if (hs) begin
            addr_reg <= in_data;
            state    <= ST_GET_DATA;
          end
        end

        ST_GET_DATA: begin
          if (hs) begin
            if (sel_ok) begin
              // Bus is loaded on the handshake edge so the write is visible next cycle.
              config_addr <= addr_reg;
              config_data <= in_data;
              hold_cnt    <= HOLD_LAST;
              in_ready    <= 1'b0;
              state       <= ST_WRITE;
            end else begin
              // Skipped record: bus untouched, count the error and move on.
              if (err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
              end
              remaining <= remaining - 16'd1;
              if (last_rec) begin
                state    <= ST_DONE;
                done     <= 1'b1;
                busy     <= 1'b0;
                in_ready <= 1'b0;
              end else begin
                state <= ST_GET_ADDR;
              end
            end
          end
        end

        ST_WRITE: begin
          if (hold_cnt == 4'd0) begin
            config_addr <= IDLE_ADDR;
            remaining   <= remaining - 16'd1;
            if (last_rec) begin
              state <= ST_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              in_ready <= 1'b1;
              state    <= ST_GET_ADDR;
            end
          end else begin
            hold_cnt <= hold_cnt - 4'd1;
          end
        end

        default: begin
          state       <= ST_IDLE;
          config_addr <= IDLE_ADDR;
          in_ready    <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_config_loader.sv
// Bench for config_loader: two instances (1-cycle and 3-cycle bus hold), scoreboard of expected bus writes.
// Latency: n/a.
// Backpressure: stream driver honours in_ready and inserts random in_valid gaps.
module tb_config_loader;

  logic        clk;
  logic [1:0]  rst_n;
  logic [1:0]  start_s;
  logic [1:0]  in_valid;
  logic [1:0]  in_ready;
  logic [1:0]  busy;
  logic [1:0]  done;
  logic [15:0] num_rec  [2];
  logic [31:0] in_data  [2];
  logic [31:0] cfg_addr [2];
  logic [31:0] cfg_data [2];
  logic [7:0]  err_cnt  [2];

  int total = 0;
  int bad   = 0;

  // Expected bus writes {addr, data} per instance, in order.
  logic [63:0] exp_q0 [$];
  logic [63:0] exp_q1 [$];
  // Records of the load being issued.
  logic [31:0] ra [$];
  logic [31:0] rd [$];

  int          run_len [2];
  logic [63:0] run_val [2];

  config_loader #(.WRITE_CYCLES(1)) u_dut0 (
    .clk(clk), .reset(rst_n[0]), .start(start_s[0]), .num_records(num_rec[0]),
    .in_valid(in_valid[0]), .in_data(in_data[0]), .in_ready(in_ready[0]),
    .config_addr(cfg_addr[0]), .config_data(cfg_data[0]),
    .busy(busy[0]), .done(done[0]), .err_count(err_cnt[0])
  );

  config_loader #(.WRITE_CYCLES(3)) u_dut1 (
    .clk(clk), .reset(rst_n[1]), .start(start_s[1]), .num_records(num_rec[1]),
    .in_valid(in_valid[1]), .in_data(in_data[1]), .in_ready(in_ready[1]),
    .config_addr(cfg_addr[1]), .config_data(cfg_data[1]),
    .busy(busy[1]), .done(done[1]), .err_count(err_cnt[1])
  );

  always #5 clk = ~clk;

  function automatic int wc_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: event did not occur within its bound", name);
  endtask

  task automatic push_exp(input int d, input logic [63:0] v);
    if (d == 0) exp_q0.push_back(v);
    else        exp_q1.push_back(v);
  endtask

  function automatic int exp_size(input int d);
    return (d == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  // Each contiguous run of non-idle addresses is one bus write.
  task automatic mon_step(input int d);
    logic [63:0] cur;
    logic [63:0] e;
    if (!rst_n[d]) begin
      run_len[d] = 0;
      return;
    end
    cur = {cfg_addr[d], cfg_data[d]};
    if (cfg_addr[d] != 32'h0) begin
      if (run_len[d] == 0) begin
        if (exp_size(d) == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write dut%0d: got %0h expected no write", d, cur);
        end else begin
          e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
          chk($sformatf("write_pair dut%0d", d), cur, e);
        end
        run_val[d] = cur;
      end else if (cur != run_val[d]) begin
        chk($sformatf("write_stable dut%0d", d), cur, run_val[d]);
      end
      chk($sformatf("ready_low_in_write dut%0d", d), 64'(in_ready[d]), 64'd0);
      chk($sformatf("busy_in_write dut%0d", d), 64'(busy[d]), 64'd1);
      run_len[d]++;
    end else if (run_len[d] != 0) begin
      chk($sformatf("hold_cycles dut%0d", d), 64'(run_len[d]), 64'(wc_of(d)));
      run_len[d] = 0;
    end
  endtask

  task automatic monitor_loop();
    forever begin
      @(negedge clk);
      mon_step(0);
      mon_step(1);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the word's handshake edge.
  task automatic send_word(input int d, input logic [31:0] w, input int gap);
    bit ok = 0;
    for (int g = 0; g < gap; g++) begin
      in_valid[d] = 1'b0;
      in_data[d]  = $urandom;
      @(posedge clk); #1;
      start_s[d] = 1'b0;
    end
    in_valid[d] = 1'b1;
    in_data[d]  = w;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      ok = in_ready[d];
      @(posedge clk); #1;
      start_s[d] = 1'b0;
    end
    in_valid[d] = 1'b0;
    in_data[d]  = $urandom;
    if (!ok) fail_now($sformatf("handshake_timeout dut%0d", d));
  endtask

  task automatic add_rec(input logic [31:0] a, input logic [31:0] v);
    ra.push_back(a);
    rd.push_back(v);
  endtask

  // Issues the records in ra/rd as one load; the model predicts writes and errors.
  task automatic do_load(input int d, input int gmin, input int gmax, input bit restart_mid);
    int n    = ra.size();
    int errs = 0;
    bit ok   = 0;
    for (int i = 0; i < n; i++) begin
      int s = int'(ra[i][31:16]);
      if (s >= 4 && s <= 7) push_exp(d, {ra[i], rd[i]});
      else errs++;
    end
    if (errs > 255) errs = 255;
    num_rec[d] = 16'(n);
    start_s[d] = 1'b1;
    for (int i = 0; i < n; i++) begin
      send_word(d, ra[i], (i == 0) ? 0 : int'($urandom_range(gmin, gmax)));
      num_rec[d] = 16'($urandom);
      if (restart_mid && i == 0) begin
        start_s[d] = 1'b1;
        num_rec[d] = 16'(n + 5);
      end
      send_word(d, rd[i], int'($urandom_range(gmin, gmax)));
    end
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      ok = done[d];
    end
    if (!ok) begin
      fail_now($sformatf("done_timeout dut%0d", d));
    end else begin
      chk($sformatf("err_count dut%0d", d), 64'(err_cnt[d]), 64'(errs));
      chk($sformatf("busy_at_done dut%0d", d), 64'(busy[d]), 64'd0);
      chk($sformatf("ready_at_done dut%0d", d), 64'(in_ready[d]), 64'd0);
      chk($sformatf("idle_addr_at_done dut%0d", d), 64'(cfg_addr[d]), 64'd0);
      chk($sformatf("writes_pending dut%0d", d), 64'(exp_size(d)), 64'd0);
    end
    @(posedge clk); #1;
    ra.delete();
    rd.delete();
  endtask

  function automatic logic [31:0] rand_addr();
    logic [15:0] sel = 16'($urandom_range(0, 9));
    logic [15:0] tid = 16'($urandom);
    return {sel, tid};
  endfunction

  initial begin
    clk      = 1'b0;
    rst_n    = 2'b11;
    start_s  = 2'b00;
    in_valid = 2'b00;
    for (int d = 0; d < 2; d++) begin
      num_rec[d] = '0;
      in_data[d] = '0;
      run_len[d] = 0;
      run_val[d] = '0;
    end
    #1 rst_n = 2'b00;
    fork
      monitor_loop();
    join_none
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_addr dut%0d", d), 64'(cfg_addr[d]), 64'd0);
      chk($sformatf("rst_data dut%0d", d), 64'(cfg_data[d]), 64'd0);
      chk($sformatf("rst_ready dut%0d", d), 64'(in_ready[d]), 64'd0);
      chk($sformatf("rst_busy dut%0d", d), 64'(busy[d]), 64'd0);
      chk($sformatf("rst_done dut%0d", d), 64'(done[d]), 64'd0);
      chk($sformatf("rst_err dut%0d", d), 64'(err_cnt[d]), 64'd0);
    end
    rst_n = 2'b11;
    @(posedge clk); #1;

    // Single record, valid held high.
    add_rec(32'h0007_0003, 32'h0000_00A5);
    do_load(0, 0, 0, 0);

    // Illegal select in the middle record.
    add_rec(32'h0004_0011, $urandom);
    add_rec(32'h0002_0001, $urandom);
    add_rec(32'h0006_0022, $urandom);
    do_load(0, 0, 0, 0);

    // in_valid toggling every cycle.
    add_rec(32'h0005_1234, 32'hDEAD_BEEF);
    add_rec(32'h0007_4321, 32'h0BAD_F00D);
    do_load(0, 1, 1, 0);

    // Three-cycle hold.
    add_rec(32'h0004_0010, 32'h0000_0002);
    do_load(1, 0, 0, 0);

    // start while busy must not restart or re-sample num_records.
    add_rec(32'h0006_0100, $urandom);
    add_rec(32'h0004_0200, $urandom);
    do_load(1, 0, 1, 1);

    // Randomized loads on both instances.
    for (int it = 0; it < 12; it++) begin
      int n = int'($urandom_range(1, 6));
      for (int i = 0; i < n; i++) add_rec(rand_addr(), $urandom);
      do_load(it % 2, 0, 2, 0);
    end

    // Error counter saturation.
    for (int i = 0; i < 260; i++) add_rec({16'($urandom_range(0, 3)), 16'($urandom)}, $urandom);
    do_load(0, 0, 0, 0);

    // Reset asserted during the write cycle.
    num_rec[0] = 16'd1;
    start_s[0] = 1'b1;
    send_word(0, 32'h0005_0042, 0);
    send_word(0, 32'h0000_1234, 0);
    chk("mid_write_addr", 64'(cfg_addr[0]), 64'h0005_0042);
    rst_n[0] = 1'b0;
    #1;
    chk("rst_mid_addr", 64'(cfg_addr[0]), 64'd0);
    chk("rst_mid_busy", 64'(busy[0]), 64'd0);
    chk("rst_mid_done", 64'(done[0]), 64'd0);
    chk("rst_mid_err", 64'(err_cnt[0]), 64'd0);
    @(posedge clk); #1;
    rst_n[0] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    num_rec[0] = 16'd0;
    start_s[0] = 1'b1;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    chk("zero_done", 64'(done[0]), 64'd1);
    chk("zero_busy", 64'(busy[0]), 64'd0);
    chk("zero_ready", 64'(in_ready[0]), 64'd0);
    chk("zero_addr", 64'(cfg_addr[0]), 64'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("zero_writes_pending", 64'(exp_size(0)), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/config_loader.md
Name: config_loader

Overview:
- Initiator side of the fabric configuration bus; PE tiles are the responders.
- Accepts a stream of 32-bit words over a valid/ready handshake and pairs them into (address, data) records.
- Drives each record onto the shared config_addr/config_data bus for exactly WRITE_CYCLES clocks. Tiles decode tile_id in [15:0] and the select field in [31:16] every cycle, so an idle or wrong address must never match.
- Sits between the off-chip bitstream source and the tile array; one instance per fabric.

Parameters:
- IDLE_ADDR, 32'h0000_0000: value on config_addr whenever no write is active. Select field 0 matches no tile sub-block.
- WRITE_CYCLES, 1: cycles each record is held on the bus (range 1..15).
- SEL_MIN, 4: lowest legal select value (CLB).
- SEL_MAX, 7: highest legal select value (SB).

Ports:
- clk, input, 1: single clock; all state on the rising edge.
- reset, input, 1: asynchronous, active-low; 0 forces reset state immediately.
- start, input, 1: one-cycle pulse that begins a load; ignored unless in IDLE or DONE.
- num_records, input, 16: records to load; sampled on start.
- in_valid, input, 1: stream word valid.
- in_data, input, 32: stream word. Order per record is address, then data.
- in_ready, output, 1: loader accepts in_data this cycle.
- config_addr, output, 32: configuration address bus to tiles.
- config_data, output, 32: configuration data bus to tiles.
- busy, output, 1: load in progress.
- done, output, 1: high from load completion until the next start.
- err_count, output, 8: records skipped for an illegal select field; saturates at 255.

Behaviour:
- Reset values: config_addr=IDLE_ADDR, config_data=0, in_ready=0, busy=0, done=0, err_count=0, state=IDLE.
- States and transitions:
  - IDLE: on start with num_records=0, go to DONE the next cycle. On start otherwise, latch remaining=num_records, clear err_count and done, go to GET_ADDR.
  - GET_ADDR: in_ready=1. When in_valid and in_ready, register the word into addr_reg and go to GET_DATA.
  - GET_DATA: in_ready=1. When the handshake completes, register data_reg.
    - If addr_reg[31:16] is within [SEL_MIN, SEL_MAX], go to WRITE.
    - Otherwise increment err_count (saturating), decrement remaining, and go to GET_ADDR, or to DONE if remaining becomes 0. The bus is never driven for a skipped record.
  - WRITE: config_addr=addr_reg and config_data=data_reg for exactly WRITE_CYCLES cycles; in_ready=0. On the last cycle, decrement remaining and go to GET_ADDR, or to DONE if remaining becomes 0.
  - DONE: done=1, busy=0. On start, behave exactly as IDLE.
- Outputs are registered; config_addr/config_data change only on state transitions into or out of WRITE.
- config_addr equals IDLE_ADDR in every cycle outside WRITE. config_data holds its last value outside WRITE; tiles ignore it there.
- busy is 1 in GET_ADDR, GET_DATA and WRITE.
- Handshake:
  - A word transfers only when in_valid and in_ready are both high at a rising edge.
  - in_data and in_valid may change freely while in_ready=0.
  - in_valid gaps stall the FSM in GET_* indefinitely with no timeout.
- Latency: the first WRITE cycle appears on the bus one cycle after the data-word handshake edge. Back-to-back throughput is WRITE_CYCLES+2 cycles per record.
- Boundary conditions:
  - start while busy: ignored, and num_records is not re-sampled.
  - num_records=16'hFFFF: counts all 65535 records correctly, with no wrap.
  - err_count at 255: stays at 255.
  - reset low mid-WRITE: config_addr returns to IDLE_ADDR asynchronously in the same cycle. No partial record is replayed after reset.
  - start and a handshake in the same cycle while in IDLE: the word is not consumed, because in_ready=0 in IDLE.

Decomposition:
- Shared package holds:
  - config select constants CONFIG_SB=7, CONFIG_CB0=6, CONFIG_CB1=5, CONFIG_CLB=4;
  - address field positions: tile_id [15:0], select [31:16];
  - the state encoding.
- The tile decode logic uses the same package.
- No sub-module. The write-hold counter and record counter are inline.

Test Plan:
- Single record (WRITE_CYCLES=1): start with num_records=1; send 0x0007_0003, then 0x0000_00A5 with in_valid held high.
  - Required: config_addr=0x0007_0003 and config_data=0x0000_00A5 for exactly 1 cycle; IDLE_ADDR before and after.
  - Required: done=1, err_count=0.
- Illegal select: num_records=3, with the middle record's address 0x0002_0001.
  - Required: only 2 bus writes occur; err_count=1; done=1.
- Stalled stream: in_valid toggles 1/0 every cycle across 2 records.
  - Required: no word is lost or duplicated, and bus values match the sent pairs in order.
- Hold length: WRITE_CYCLES=3, one record 0x0004_0010 / 0x2.
  - Required: the address is held exactly 3 cycles; in_ready=0 throughout those 3 cycles.
- Reset mid-write: drive reset=0 during the WRITE cycle.
  - Required: config_addr=IDLE_ADDR before the next edge, busy=0, done=0, err_count=0.
  - Then start with num_records=0. Required: done=1 one cycle after start, with no bus activity.
